cross_ctrl_sched: RTL and testbench
===================================

// Module: cross_ctrl_sched
// PURPOSE
//  Registered crossbar control generator with conflict scheduling. Accepts one group of NUM_IN
//  destination indices plus an element-valid mask and emits one or more NUM_OUT x NUM_IN one-hot
//  control beats. When several inputs target one output, the group is split over several beats.
//  Sits between the sparse-index decoder and the data crossbar; valid/ready on both sides.
// PARAMETERS
//  NUM_IN   8   number of crossbar inputs (columns)
//  NUM_OUT  8   number of crossbar outputs (rows)
//  DW_IDX   3   width of each destination index; must be >= $clog2(NUM_OUT)
//  CNT_W    16  width of the saturating conflict-group counter
//  localparam DW_PASS = max(1,$clog2(NUM_IN)) -- beat index width within a group
// PORTS
//  clk           in   1                 clock, all state on posedge
//  rst           in   1                 synchronous reset, active-high
//  in_valid      in   1                 input group valid
//  in_ready      out  1                 block can accept a group this cycle
//  in_idx        in   NUM_IN*DW_IDX     dest index of input i at [i*DW_IDX +: DW_IDX]
//  in_mask       in   NUM_IN            1 = input i carries a nonzero element
//  out_valid     out  1                 control beat valid
//  out_ready     in   1                 downstream consumes beat
//  out_ctrl      out  NUM_OUT*NUM_IN    bit [o*NUM_IN+i] = 1: route input i to output o
//  out_last      out  1                 final beat of current group
//  out_pass      out  DW_PASS           beat number within group, 0-based
//  out_err_oor   out  NUM_IN            input i masked-in with idx >= NUM_OUT (pass 0 only)
//  conflict_cnt  out  CNT_W             groups that needed >1 beat, saturating
// BEHAVIOUR
//  State: IDLE / ISSUE; regs idx_q, pend_q[NUM_IN], oor_q[NUM_IN], pass_q, conflict_cnt.
//  Reset: state=IDLE, pend_q=0, oor_q=0, pass_q=0, conflict_cnt=0 -> out_valid=0, out_ctrl=0,
//   out_last=0, out_pass=0, out_err_oor=0, in_ready=1. Reset mid-group discards the group.
//  in_ready = (state==IDLE) | (out_valid & out_ready & out_last). Accept = in_valid & in_ready.
//  On accept: idx_q<=in_idx; oor_q[i]<=in_mask[i]&(idx_i>=NUM_OUT);
//   pend_q[i]<=in_mask[i]&(idx_i<NUM_OUT); pass_q<=0; state<=ISSUE.
//  Latency: out_valid first high the cycle after accept; back-to-back groups have no bubble.
//  In ISSUE (out_valid=1): grant[i] = pend_q[i] & no pend_q[k], k<i, with idx_q[k]==idx_q[i]
//   (lowest-index input wins each output). out_ctrl[o*NUM_IN+i] = grant[i] & (idx_q[i]==o).
//   Each row and each column of out_ctrl is at most one-hot.
//  out_last = ((pend_q & ~grant) == 0). out_pass = pass_q. out_err_oor = oor_q when pass_q==0, else 0.
//  out_valid & out_ready & !out_last: pend_q<=pend_q&~grant, pass_q++; stay ISSUE.
//  out_valid & out_ready & out_last: if conflict group (pass_q!=0) conflict_cnt++ (hold at
//   2^CNT_W-1); then load new group if in_valid, else state<=IDLE, pend_q=0.
//  out_valid & !out_ready: all outputs and state held stable (no change of ctrl under stall).
//  Empty group (mask all 0 or all OOR): exactly one beat, out_ctrl=0, out_last=1, out_pass=0.
//  Max beats per group = NUM_IN (all inputs to one output); pass_q never wraps.
//  Registered outputs only depend on state regs; out_ctrl/out_last are combinational from them.
// TESTING
//  idx=7,6,5,4,3,2,1,0 mask=FF, out_ready=1 -> 1 beat, out_ctrl[(7-i)*8+i]=1, out_last=1, cnt=0
//  all idx=2, mask=FF -> 8 beats, beat p has only bit [2*8+p] set, out_last on p=7, cnt=1
//  NUM_OUT=6, idx0=7 mask=01 -> 1 beat, out_ctrl=0, out_err_oor=01, out_last=1
//  idx0=idx1=3, others distinct, out_ready low 5 cycles on beat 0 -> beat stable, then 2 beats
//  two groups with in_valid held high -> second group's beat 0 in cycle after first out_last
//  rst asserted during beat 3 of 8 -> next cycle out_valid=0, in_ready=1, cnt=0

Source files
------------

// File: rtl/cross_ctrl_sched.sv
// cross_ctrl_sched
//   Registered crossbar control generator with conflict scheduling. One group of
//   NUM_IN destination indices plus an element-valid mask is accepted and emitted
//   as one or more NUM_OUT x NUM_IN one-hot control beats. Inputs that collide on
//   an output are spread over successive beats, lowest input index first.
//
// Ports
//   clk_i           clock, all state on posedge
//   rst_i           synchronous reset, active-high
//   in_valid_i      input group valid
//   in_ready_o      block can accept a group this cycle
//   in_idx_i        dest index of input i at [i*DW_IDX +: DW_IDX]
//   in_mask_i       1 = input i carries a nonzero element
//   out_valid_o     control beat valid
//   out_ready_i     downstream consumes beat
//   out_ctrl_o      bit [o*NUM_IN+i] = 1: route input i to output o
//   out_last_o      final beat of current group
//   out_pass_o      beat number within group, 0-based
//   out_err_oor_o   input i masked-in with idx >= NUM_OUT (beat 0 only)
//   conflict_cnt_o  saturating count of groups that needed more than one beat
//
// State  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no group held, ready for a new one
// ISSUE  | group held, presenting the current beat on the output side

module cross_ctrl_sched #(
    parameter int NUM_IN  = 8,
    parameter int NUM_OUT = 8,
    parameter int DW_IDX  = 3,
    parameter int CNT_W   = 16,
    localparam int DW_PASS = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [NUM_IN*DW_IDX-1:0]    in_idx_i,
    input  logic [NUM_IN-1:0]           in_mask_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [NUM_OUT*NUM_IN-1:0]   out_ctrl_o,
    output logic                        out_last_o,
    output logic [DW_PASS-1:0]          out_pass_o,
    output logic [NUM_IN-1:0]           out_err_oor_o,
    output logic [CNT_W-1:0]            conflict_cnt_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // One extra bit so NUM_OUT == 2**DW_IDX still compares correctly.
    localparam logic [DW_IDX:0] NUM_OUT_X = (DW_IDX+1)'(NUM_OUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t                   state_q, state_d;
    logic [DW_IDX-1:0]        idx_q [NUM_IN];
    logic [DW_IDX-1:0]        idx_d [NUM_IN];
    logic [NUM_IN-1:0]        pend_q, pend_d;
    logic [NUM_IN-1:0]        oor_q, oor_d;
    logic [DW_PASS-1:0]       pass_q, pass_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic [NUM_IN-1:0]        blocked;
    logic [NUM_IN-1:0]        grant;
    logic                     issue;
    logic                     last;
    logic                     fire;
    logic                     accept;

    // ------------------------------------------------------------------
    // Grant: an input is blocked when a lower-indexed pending input targets
    // the same output. Out-of-range inputs never enter pend_q, so they
    // neither win nor block.
    // ------------------------------------------------------------------
    always_comb begin
        blocked = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            for (int k = 0; k < i; k++) begin
                if (pend_q[k] && (idx_q[k] == idx_q[i])) begin
                    blocked[i] = 1'b1;
                end
            end
        end
        grant = pend_q & ~blocked;
    end

    assign issue = (state_q == ISSUE);
    assign last  = issue && ((pend_q & ~grant) == '0);
    assign fire  = issue && out_ready_i;

    assign in_ready_o = (state_q == IDLE) || (fire && last);
    assign accept     = in_valid_i && in_ready_o;

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        out_ctrl_o = '0;
        for (int o = 0; o < NUM_OUT; o++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                out_ctrl_o[o*NUM_IN+i] = issue && grant[i] && (idx_q[i] == DW_IDX'(o));
            end
        end
    end

    assign out_valid_o    = issue;
    assign out_last_o     = last;
    assign out_pass_o     = pass_q;
    assign out_err_oor_o  = (issue && (pass_q == '0)) ? oor_q : '0;
    assign conflict_cnt_o = cnt_q;

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        oor_d   = oor_q;
        pass_d  = pass_q;
        cnt_d   = cnt_q;

        if (fire && !last) begin
            pend_d = pend_q & ~grant;
            pass_d = pass_q + DW_PASS'(1);
        end

        if (fire && last) begin
            if ((pass_q != '0) && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            state_d = IDLE;
            pend_d  = '0;
            oor_d   = '0;
            pass_d  = '0;
        end

        // A new group may load in the same cycle the previous one retires,
        // which gives back-to-back groups without a bubble.
        if (accept) begin
            for (int i = 0; i < NUM_IN; i++) begin
                idx_d[i]  = in_idx_i[i*DW_IDX +: DW_IDX];
                oor_d[i]  = in_mask_i[i] && ({1'b0, in_idx_i[i*DW_IDX +: DW_IDX]} >= NUM_OUT_X);
                pend_d[i] = in_mask_i[i] && ({1'b0, in_idx_i[i*DW_IDX +: DW_IDX]} <  NUM_OUT_X);
            end
            pass_d  = '0;
            state_d = ISSUE;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pend_q  <= '0;
            oor_q   <= '0;
            pass_q  <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            oor_q   <= oor_d;
            pass_q  <= pass_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < NUM_IN; i++) begin
                idx_q[i] <= idx_d[i];
            end
        end
    end

endmodule

// File: tb/tb_cross_ctrl_sched.sv
// Directed bench for cross_ctrl_sched: an 8x8 instance for the main scenarios
// and an 8-in / 6-out instance for out-of-range index reporting.

module tb_cross_ctrl_sched;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_idx;
    logic [7:0]  in_mask;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_ctrl;
    logic        out_last;
    logic [2:0]  out_pass;
    logic [7:0]  out_err;
    logic [15:0] cnt;

    logic        v6;
    logic        rdy6;
    logic        valid6;
    logic [47:0] ctrl6;
    logic        last6;
    logic [2:0]  pass6;
    logic [7:0]  err6;
    logic [15:0] cnt6;

    int n_cmp = 0;
    int n_err = 0;

    cross_ctrl_sched #(.NUM_IN(8), .NUM_OUT(8), .DW_IDX(3), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_idx_i(in_idx), .in_mask_i(in_mask),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_ctrl_o(out_ctrl), .out_last_o(out_last), .out_pass_o(out_pass),
        .out_err_oor_o(out_err), .conflict_cnt_o(cnt)
    );

    cross_ctrl_sched #(.NUM_IN(8), .NUM_OUT(6), .DW_IDX(3), .CNT_W(16)) dut6 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(v6), .in_ready_o(rdy6),
        .in_idx_i(in_idx), .in_mask_i(in_mask),
        .out_valid_o(valid6), .out_ready_i(out_ready),
        .out_ctrl_o(ctrl6), .out_last_o(last6), .out_pass_o(pass6),
        .out_err_oor_o(err6), .conflict_cnt_o(cnt6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        n_cmp++; if (out_ctrl !== 64'd0) begin n_err++; $display("FAIL reset_ctrl got=%h exp=0", out_ctrl); end
        n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_last got=%0b exp=0", out_last); end
        n_cmp++; if (out_pass !== 3'd0) begin n_err++; $display("FAIL reset_pass got=%0d exp=0", out_pass); end
        n_cmp++; if (out_err !== 8'h00) begin n_err++; $display("FAIL reset_err got=%h exp=00", out_err); end
        n_cmp++; if (cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    endtask

    task automatic test_permutation();
        logic [63:0] exp_ctrl;
        exp_ctrl = '0;
        for (int i = 0; i < 8; i++) exp_ctrl[(7-i)*8+i] = 1'b1;
        out_ready = 1'b1;
        in_idx    = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        in_mask   = 8'hFF;
        in_valid  = 1'b1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL perm_in_ready got=%0b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL perm_valid got=%0b exp=1", out_valid); end
        n_cmp++; if (out_ctrl !== exp_ctrl) begin n_err++; $display("FAIL perm_ctrl got=%h exp=%h", out_ctrl, exp_ctrl); end
        n_cmp++; if (out_last !== 1'b1) begin n_err++; $display("FAIL perm_last got=%0b exp=1", out_last); end
        n_cmp++; if (out_pass !== 3'd0) begin n_err++; $display("FAIL perm_pass got=%0d exp=0", out_pass); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL perm_idle got=%0b exp=0", out_valid); end
        n_cmp++; if (cnt !== 16'd0) begin n_err++; $display("FAIL perm_cnt got=%0d exp=0", cnt); end
    endtask

    task automatic test_all_same();
        logic [63:0] exp_ctrl;
        out_ready = 1'b1;
        in_idx    = {8{3'd2}};
        in_mask   = 8'hFF;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int p = 0; p < 8; p++) begin
            exp_ctrl = '0;
            exp_ctrl[2*8+p] = 1'b1;
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL same_valid beat=%0d got=%0b exp=1", p, out_valid); end
            n_cmp++; if (out_ctrl !== exp_ctrl) begin n_err++; $display("FAIL same_ctrl beat=%0d got=%h exp=%h", p, out_ctrl, exp_ctrl); end
            n_cmp++; if (out_last !== (p == 7)) begin n_err++; $display("FAIL same_last beat=%0d got=%0b exp=%0b", p, out_last, (p == 7)); end
            n_cmp++; if (out_pass !== 3'(p)) begin n_err++; $display("FAIL same_pass beat=%0d got=%0d exp=%0d", p, out_pass, p); end
            tick();
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL same_idle got=%0b exp=0", out_valid); end
        n_cmp++; if (cnt !== 16'd1) begin n_err++; $display("FAIL same_cnt got=%0d exp=1", cnt); end
    endtask

    task automatic test_oor();
        out_ready = 1'b1;
        in_idx    = {21'd0, 3'd7};
        in_mask   = 8'h01;
        v6        = 1'b1;
        tick();
        v6 = 1'b0;
        n_cmp++; if (valid6 !== 1'b1) begin n_err++; $display("FAIL oor_valid got=%0b exp=1", valid6); end
        n_cmp++; if (ctrl6 !== 48'd0) begin n_err++; $display("FAIL oor_ctrl got=%h exp=0", ctrl6); end
        n_cmp++; if (err6 !== 8'h01) begin n_err++; $display("FAIL oor_err got=%h exp=01", err6); end
        n_cmp++; if (last6 !== 1'b1) begin n_err++; $display("FAIL oor_last got=%0b exp=1", last6); end
        n_cmp++; if (pass6 !== 3'd0) begin n_err++; $display("FAIL oor_pass got=%0d exp=0", pass6); end
        tick();
        n_cmp++; if (valid6 !== 1'b0) begin n_err++; $display("FAIL oor_idle got=%0b exp=0", valid6); end
        n_cmp++; if (err6 !== 8'h00) begin n_err++; $display("FAIL oor_err_idle got=%h exp=00", err6); end
        n_cmp++; if (cnt6 !== 16'd0) begin n_err++; $display("FAIL oor_cnt got=%0d exp=0", cnt6); end
    endtask

    task automatic test_stall();
        logic [63:0] exp0;
        logic [63:0] exp1;
        // inputs 0..7 -> outputs 3,3,0,1,2,4,5,6
        exp0 = '0;
        exp0[3*8+0] = 1'b1;
        exp0[0*8+2] = 1'b1;
        exp0[1*8+3] = 1'b1;
        exp0[2*8+4] = 1'b1;
        exp0[4*8+5] = 1'b1;
        exp0[5*8+6] = 1'b1;
        exp0[6*8+7] = 1'b1;
        exp1 = '0;
        exp1[3*8+1] = 1'b1;
        out_ready = 1'b0;
        in_idx    = {3'd6, 3'd5, 3'd4, 3'd2, 3'd1, 3'd0, 3'd3, 3'd3};
        in_mask   = 8'hFF;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (out_ctrl !== exp0) begin n_err++; $display("FAIL stall_ctrl cyc=%0d got=%h exp=%h", c, out_ctrl, exp0); end
            n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL stall_last cyc=%0d got=%0b exp=0", c, out_last); end
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid cyc=%0d got=%0b exp=1", c, out_valid); end
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready cyc=%0d got=%0b exp=0", c, in_ready); end
            tick();
        end
        out_ready = 1'b1;
        n_cmp++; if (out_ctrl !== exp0) begin n_err++; $display("FAIL stall_release_ctrl got=%h exp=%h", out_ctrl, exp0); end
        n_cmp++; if (out_pass !== 3'd0) begin n_err++; $display("FAIL stall_release_pass got=%0d exp=0", out_pass); end
        tick();
        n_cmp++; if (out_ctrl !== exp1) begin n_err++; $display("FAIL stall_beat1_ctrl got=%h exp=%h", out_ctrl, exp1); end
        n_cmp++; if (out_last !== 1'b1) begin n_err++; $display("FAIL stall_beat1_last got=%0b exp=1", out_last); end
        n_cmp++; if (out_pass !== 3'd1) begin n_err++; $display("FAIL stall_beat1_pass got=%0d exp=1", out_pass); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_idle got=%0b exp=0", out_valid); end
        n_cmp++; if (cnt !== 16'd2) begin n_err++; $display("FAIL stall_cnt got=%0d exp=2", cnt); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_b;
        exp_b = '0;
        for (int i = 0; i < 8; i++) exp_b[(7-i)*8+i] = 1'b1;
        out_ready = 1'b1;
        in_idx    = {8{3'd5}};
        in_mask   = 8'h03;
        in_valid  = 1'b1;
        tick();
        in_idx  = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        in_mask = 8'hFF;
        n_cmp++; if (out_ctrl !== 64'd1 << 40) begin n_err++; $display("FAIL b2b_a0_ctrl got=%h exp=%h", out_ctrl, 64'd1 << 40); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_a0_in_ready got=%0b exp=0", in_ready); end
        tick();
        n_cmp++; if (out_ctrl !== 64'd1 << 41) begin n_err++; $display("FAIL b2b_a1_ctrl got=%h exp=%h", out_ctrl, 64'd1 << 41); end
        n_cmp++; if (out_last !== 1'b1) begin n_err++; $display("FAIL b2b_a1_last got=%0b exp=1", out_last); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_a1_in_ready got=%0b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_b0_valid got=%0b exp=1", out_valid); end
        n_cmp++; if (out_ctrl !== exp_b) begin n_err++; $display("FAIL b2b_b0_ctrl got=%h exp=%h", out_ctrl, exp_b); end
        n_cmp++; if (out_pass !== 3'd0) begin n_err++; $display("FAIL b2b_b0_pass got=%0d exp=0", out_pass); end
        n_cmp++; if (cnt !== 16'd3) begin n_err++; $display("FAIL b2b_cnt got=%0d exp=3", cnt); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle got=%0b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        in_idx    = {8{3'd2}};
        in_mask   = 8'hFF;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        n_cmp++; if (out_pass !== 3'd3) begin n_err++; $display("FAIL rstmid_pass3 got=%0d exp=3", out_pass); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got=%0b exp=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready got=%0b exp=1", in_ready); end
        n_cmp++; if (cnt !== 16'd0) begin n_err++; $display("FAIL rstmid_cnt got=%0d exp=0", cnt); end
        n_cmp++; if (out_pass !== 3'd0) begin n_err++; $display("FAIL rstmid_pass got=%0d exp=0", out_pass); end
        n_cmp++; if (out_ctrl !== 64'd0) begin n_err++; $display("FAIL rstmid_ctrl got=%h exp=0", out_ctrl); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_stay_idle got=%0b exp=0", out_valid); end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        v6        = 1'b0;
        out_ready = 1'b0;
        in_idx    = '0;
        in_mask   = '0;
        tick();
        test_reset();
        test_permutation();
        test_all_same();
        test_oor();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
